// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into AW/W/B or AR/R
// traffic and reports completion with a one-cycle rsp_valid pulse.
module axi4_lite_master_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  M_AXI_ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;

    // One latched address serves both channels; only one transaction is ever in flight.
    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARADDR = addr;

    always_ff @(posedge clk or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            addr          <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        addr        <= cmd_addr;
                        M_AXI_WDATA <= cmd_wdata;
                        M_AXI_WSTRB <= cmd_wstrb;
                        // Misaligned commands are answered locally without touching the bus.
                        if (cmd_addr[1:0] != 2'b00) begin
                            rsp_valid <= 1'b1;
                            rsp_resp  <= 2'b10;
                            rsp_rdata <= '0;
                        end else if (cmd_write) begin
                            cmd_ready     <= 1'b0;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            cmd_ready     <= 1'b0;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        cmd_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                READ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        cmd_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
